// File: rtl/factor_row_server.sv
// Factor row server: queues per-mode row read requests, reads one factor memory per
// mode and returns the rows, in acceptance order, tagged with the requesting unit id.
module factor_row_server #(
    parameter int TENSOR_DIMENSIONS      = 3,
    parameter int FACTOR_MATRIX_WIDTH    = 32,
    parameter int RANK_FACTOR_MATRIX     = 16,
    parameter int MODE_TENSOR_ADDR_WIDTH = 16,
    parameter int NUM_COMPUTE_UNITS      = 320,
    parameter int FACTOR_MEM_DEPTH       = 1024,
    parameter int REQ_FIFO_DEPTH         = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic [TENSOR_DIMENSIONS-2:0] req_addr_en,
    input  logic [(TENSOR_DIMENSIONS-1)*MODE_TENSOR_ADDR_WIDTH-1:0] req_addr,
    input  logic [$clog2(NUM_COMPUTE_UNITS):0] req_compute_id,
    output logic req_ready,
    output logic factor_data_ack,
    input  logic wr_en,
    input  logic [$clog2(TENSOR_DIMENSIONS-1):0] wr_mode,
    input  logic [$clog2(FACTOR_MEM_DEPTH)-1:0] wr_addr,
    input  logic [RANK_FACTOR_MATRIX*FACTOR_MATRIX_WIDTH-1:0] wr_data,
    output logic [TENSOR_DIMENSIONS-2:0] resp_factor_matrices_en,
    output logic [(TENSOR_DIMENSIONS-1)*RANK_FACTOR_MATRIX*FACTOR_MATRIX_WIDTH-1:0] resp_factor_matrices,
    output logic [$clog2(NUM_COMPUTE_UNITS):0] resp_compute_id,
    output logic err_oob
);

    localparam int NM    = TENSOR_DIMENSIONS - 1;
    localparam int CIDW  = $clog2(NUM_COMPUTE_UNITS) + 1;
    localparam int MAW   = $clog2(FACTOR_MEM_DEPTH);
    localparam int WMW   = $clog2(NM) + 1;
    localparam int AW    = MODE_TENSOR_ADDR_WIDTH;
    localparam int ROW_W = RANK_FACTOR_MATRIX * FACTOR_MATRIX_WIDTH;
    localparam int PW    = $clog2(REQ_FIFO_DEPTH);
    localparam int CW    = PW + 1;

    logic [NM-1:0]    fifo_en   [REQ_FIFO_DEPTH];
    logic [NM*AW-1:0] fifo_addr [REQ_FIFO_DEPTH];
    logic [CIDW-1:0]  fifo_id   [REQ_FIFO_DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count;

    logic             push;
    logic             pop;
    logic [NM-1:0]    head_en;
    logic [NM*AW-1:0] head_addr;
    logic [CIDW-1:0]  head_id;
    logic [NM-1:0]    oob_mask;

    logic             s1_valid;
    logic [NM-1:0]    s1_en;
    logic [NM-1:0]    s1_oob;
    logic [CIDW-1:0]  s1_id;

    // A load owns the single memory port, so the queue only drains on write-free cycles.
    assign req_ready = (count != CW'(REQ_FIFO_DEPTH));
    assign push      = (|req_addr_en) && req_ready;
    assign pop       = (count != '0) && !wr_en;
    assign head_en   = fifo_en[rd_ptr];
    assign head_addr = fifo_addr[rd_ptr];
    assign head_id   = fifo_id[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_en[wr_ptr]   <= req_addr_en;
            fifo_addr[wr_ptr] <= req_addr;
            fifo_id[wr_ptr]   <= req_compute_id;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr          <= '0;
            rd_ptr          <= '0;
            count           <= '0;
            factor_data_ack <= 1'b0;
        end else begin
            factor_data_ack <= push;
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            if (push && !pop)      count <= count + CW'(1);
            else if (pop && !push) count <= count - CW'(1);
        end
    end

    // Issue stage: remembers which modes were read and which were out of range.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_valid <= 1'b0;
            s1_en    <= '0;
            s1_oob   <= '0;
            s1_id    <= '0;
            err_oob  <= 1'b0;
        end else begin
            s1_valid <= pop;
            if (pop) begin
                s1_en  <= head_en;
                s1_oob <= head_en & oob_mask;
                s1_id  <= head_id;
                if (|(head_en & oob_mask)) err_oob <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            resp_factor_matrices_en <= '0;
            resp_compute_id         <= '0;
        end else begin
            resp_factor_matrices_en <= s1_valid ? s1_en : '0;
            if (s1_valid) resp_compute_id <= s1_id;
        end
    end

    for (genvar m = 0; m < NM; m++) begin : g_mode
        logic [ROW_W-1:0] mem [FACTOR_MEM_DEPTH];
        logic [ROW_W-1:0] rd_data;
        logic [ROW_W-1:0] resp_row;
        logic [AW-1:0]    head_row;

        assign head_row    = head_addr[m*AW +: AW];
        assign oob_mask[m] = 32'(head_row) >= $unsigned(FACTOR_MEM_DEPTH);

        // Single-port memory: loads win, reads only happen on the cycle of a pop.
        always_ff @(posedge clk) begin
            if (wr_en && (wr_mode == WMW'(m)))
                mem[wr_addr] <= wr_data;
            else if (pop && head_en[m] && !oob_mask[m])
                rd_data <= mem[head_row[MAW-1:0]];
        end

        always_ff @(posedge clk or negedge rst) begin
            if (!rst)
                resp_row <= '0;
            else if (s1_valid)
                resp_row <= (s1_en[m] && !s1_oob[m]) ? rd_data : '0;
        end

        assign resp_factor_matrices[m*ROW_W +: ROW_W] = resp_row;
    end

endmodule

// File: tb/tb_factor_row_server.sv
// Directed bench for factor_row_server: hand-computed rows, ids and cycle positions
// for loading, latency, write priority, out-of-range reads, ordering and reset.
module tb_factor_row_server;

    logic         clk;
    logic         rst;
    logic [1:0]   req_addr_en;
    logic [31:0]  req_addr;
    logic [9:0]   req_compute_id;
    logic         req_ready;
    logic         factor_data_ack;
    logic         wr_en;
    logic [1:0]   wr_mode;
    logic [9:0]   wr_addr;
    logic [511:0] wr_data;
    logic [1:0]   resp_en;
    logic [1023:0] resp_data;
    logic [9:0]   resp_id;
    logic         err_oob;

    int total = 0;
    int bad   = 0;

    logic [511:0] row_a;
    logic [511:0] row_b;
    logic [511:0] row_c;
    logic [9:0]   id_q[$];
    int           ack_cnt;
    int           resp_cnt;
    int           first_tick;
    int           last_tick;
    bit           first_seen;

    factor_row_server dut (
        .clk                     (clk),
        .rst                     (rst),
        .req_addr_en             (req_addr_en),
        .req_addr                (req_addr),
        .req_compute_id          (req_compute_id),
        .req_ready               (req_ready),
        .factor_data_ack         (factor_data_ack),
        .wr_en                   (wr_en),
        .wr_mode                 (wr_mode),
        .wr_addr                 (wr_addr),
        .wr_data                 (wr_data),
        .resp_factor_matrices_en (resp_en),
        .resp_factor_matrices    (resp_data),
        .resp_compute_id         (resp_id),
        .err_oob                 (err_oob)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [511:0] observed, input logic [511:0] expected);
        total++;
        if (observed !== expected) begin
            bad++;
            $display("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Drive one cycle of inputs, then return 1 time unit after the capturing edge.
    task automatic applyStimulus(input logic [1:0] en, input logic [15:0] a0, input logic [15:0] a1,
                                 input logic [9:0] id, input logic we, input logic [1:0] wm,
                                 input logic [9:0] wa, input logic [31:0] word);
        req_addr_en    = en;
        req_addr       = {a1, a0};
        req_compute_id = id;
        wr_en          = we;
        wr_mode        = wm;
        wr_addr        = wa;
        wr_data        = {16{word}};
        @(posedge clk);
        #1;
    endtask

    task automatic idleCycle();
        applyStimulus(2'b00, 16'd0, 16'd0, 10'd0, 1'b0, 2'd0, 10'd0, 32'd0);
    endtask

    initial begin
        row_a = {16{32'h11111111}};
        row_b = {16{32'h22222222}};
        row_c = {16{32'h33333333}};
        req_addr_en = '0; req_addr = '0; req_compute_id = '0;
        wr_en = 1'b0; wr_mode = '0; wr_addr = '0; wr_data = '0;
        rst = 1'b1;
        #2 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_ready", 512'(req_ready), 512'(1));
        checkOutput("rst_ack", 512'(factor_data_ack), 512'(0));
        checkOutput("rst_en", 512'(resp_en), 512'(0));
        checkOutput("rst_data0", resp_data[511:0], '0);
        checkOutput("rst_data1", resp_data[1023:512], '0);
        checkOutput("rst_id", 512'(resp_id), 512'(0));
        checkOutput("rst_oob", 512'(err_oob), 512'(0));
        rst = 1'b1;

        // Basic load and two-mode read with exact latency.
        applyStimulus(2'b00, 16'd0, 16'd0, 10'd0, 1'b1, 2'd0, 10'd5, 32'h11111111);
        applyStimulus(2'b00, 16'd0, 16'd0, 10'd0, 1'b1, 2'd1, 10'd9, 32'h22222222);
        applyStimulus(2'b11, 16'd5, 16'd9, 10'd7, 1'b0, 2'd0, 10'd0, 32'd0);
        checkOutput("basic_ack_t1", 512'(factor_data_ack), 512'(1));
        checkOutput("basic_en_t1", 512'(resp_en), 512'(0));
        idleCycle();
        checkOutput("basic_ack_t2", 512'(factor_data_ack), 512'(0));
        checkOutput("basic_en_t2", 512'(resp_en), 512'(0));
        idleCycle();
        checkOutput("basic_en_t3", 512'(resp_en), 512'(2'b11));
        checkOutput("basic_data0", resp_data[511:0], row_a);
        checkOutput("basic_data1", resp_data[1023:512], row_b);
        checkOutput("basic_id", 512'(resp_id), 512'(7));
        idleCycle();
        checkOutput("basic_en_drop", 512'(resp_en), 512'(0));
        checkOutput("basic_id_hold", 512'(resp_id), 512'(7));
        checkOutput("basic_oob_clear", 512'(err_oob), 512'(0));

        // Out-of-range row on mode 0; mode 1 disabled must read back zero.
        applyStimulus(2'b01, 16'd2000, 16'd9, 10'd3, 1'b0, 2'd0, 10'd0, 32'd0);
        idleCycle();
        idleCycle();
        checkOutput("oob_en", 512'(resp_en), 512'(2'b01));
        checkOutput("oob_data0", resp_data[511:0], '0);
        checkOutput("oob_data1", resp_data[1023:512], '0);
        checkOutput("oob_id", 512'(resp_id), 512'(3));
        checkOutput("oob_flag", 512'(err_oob), 512'(1));

        // Read-after-write on row 3.
        applyStimulus(2'b00, 16'd0, 16'd0, 10'd0, 1'b1, 2'd0, 10'd3, 32'h33333333);
        applyStimulus(2'b01, 16'd3, 16'd0, 10'd4, 1'b0, 2'd0, 10'd0, 32'd0);
        idleCycle();
        idleCycle();
        checkOutput("raw_en", 512'(resp_en), 512'(2'b01));
        checkOutput("raw_data0", resp_data[511:0], row_c);
        checkOutput("raw_data1", resp_data[1023:512], '0);
        checkOutput("raw_id", 512'(resp_id), 512'(4));
        checkOutput("oob_sticky", 512'(err_oob), 512'(1));

        // Write priority: loads to a non-existent mode stall the queue, which fills at 4.
        ack_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            checkOutput($sformatf("wp_ready_%0d", i), 512'(req_ready), 512'(i < 4));
            applyStimulus(2'b11, 16'd5, 16'd9, 10'(20 + i), 1'b1, 2'd2, 10'd5, 32'hDEADBEEF);
            if (factor_data_ack) ack_cnt++;
        end
        checkOutput("wp_ready_full", 512'(req_ready), 512'(0));
        id_q.delete();
        first_seen = 1'b0;
        for (int k = 0; k < 8; k++) begin
            idleCycle();
            if (factor_data_ack) ack_cnt++;
            if (resp_en != 2'b00) begin
                id_q.push_back(resp_id);
                if (!first_seen) begin
                    first_seen = 1'b1;
                    checkOutput("wp_mode2_ignored", resp_data[511:0], row_a);
                end
            end
        end
        checkOutput("wp_acks", 512'(ack_cnt), 512'(4));
        checkOutput("wp_resps", 512'(id_q.size()), 512'(4));
        for (int j = 0; j < id_q.size(); j++)
            checkOutput($sformatf("wp_id_%0d", j), 512'(id_q[j]), 512'(20 + j));

        // Sixteen back-to-back requests stream out one response per cycle.
        ack_cnt = 0;
        id_q.delete();
        first_tick = -1;
        last_tick  = -1;
        for (int t = 0; t < 24; t++) begin
            if (t < 16)
                applyStimulus(2'b11, 16'd5, 16'd9, 10'(100 + t), 1'b0, 2'd0, 10'd0, 32'd0);
            else
                idleCycle();
            if (factor_data_ack) ack_cnt++;
            if (resp_en != 2'b00) begin
                id_q.push_back(resp_id);
                if (first_tick < 0) first_tick = t;
                last_tick = t;
            end
        end
        checkOutput("b2b_acks", 512'(ack_cnt), 512'(16));
        checkOutput("b2b_resps", 512'(id_q.size()), 512'(16));
        checkOutput("b2b_first", 512'(first_tick), 512'(2));
        checkOutput("b2b_span", 512'(last_tick - first_tick + 1), 512'(16));
        for (int j = 0; j < id_q.size(); j++)
            checkOutput($sformatf("b2b_id_%0d", j), 512'(id_q[j]), 512'(100 + j));

        // Reset with three requests queued and one in flight.
        for (int i = 0; i < 4; i++)
            applyStimulus(2'b11, 16'd5, 16'd9, 10'(30 + i), 1'b1, 2'd2, 10'd0, 32'd0);
        idleCycle();
        rst = 1'b0;
        #1;
        checkOutput("mid_rst_ack", 512'(factor_data_ack), 512'(0));
        checkOutput("mid_rst_en", 512'(resp_en), 512'(0));
        checkOutput("mid_rst_data0", resp_data[511:0], '0);
        checkOutput("mid_rst_id", 512'(resp_id), 512'(0));
        checkOutput("mid_rst_ready", 512'(req_ready), 512'(1));
        checkOutput("mid_rst_oob", 512'(err_oob), 512'(0));
        #2 rst = 1'b1;
        ack_cnt  = 0;
        resp_cnt = 0;
        for (int k = 0; k < 8; k++) begin
            idleCycle();
            if (factor_data_ack) ack_cnt++;
            if (resp_en != 2'b00) resp_cnt++;
        end
        checkOutput("post_rst_resps", 512'(resp_cnt), 512'(0));
        checkOutput("post_rst_acks", 512'(ack_cnt), 512'(0));
        checkOutput("post_rst_ready", 512'(req_ready), 512'(1));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/factor_row_server.md
FACTOR_ROW_SERVER -- requirements
Module: factor_row_server

Interface
REQ-001 Parameters (name, default, meaning), one per line:
 TENSOR_DIMENSIONS, 3, tensor order; NM = TENSOR_DIMENSIONS-1 factor modes served.
 FACTOR_MATRIX_WIDTH, 32, bits per factor element.
 RANK_FACTOR_MATRIX, 16, elements per factor row.
 MODE_TENSOR_ADDR_WIDTH, 16, request row-address width.
 NUM_COMPUTE_UNITS, 320, compute units; CIDW = $clog2(NUM_COMPUTE_UNITS)+1.
 FACTOR_MEM_DEPTH, 1024, rows per mode memory (power of 2); MAW = $clog2(FACTOR_MEM_DEPTH).
 REQ_FIFO_DEPTH, 4, request queue entries (power of 2, >=2).
REQ-002 Ports (name  direction  width  meaning), clock and reset first:
 clk  in  1  single clock; all logic rising-edge.
 rst  in  1  reset; asynchronous assert, active-low (0 = reset).
 req_addr_en  in  NM  per-mode read request bits; any bit set = request.
 req_addr  in  NM x MODE_TENSOR_ADDR_WIDTH  row address per mode.
 req_compute_id  in  CIDW  requesting compute-unit id.
 req_ready  out  1  queue can accept a request this cycle.
 factor_data_ack  out  1  one-cycle pulse: request accepted.
 wr_en  in  1  factor memory load strobe.
 wr_mode  in  $clog2(NM)+1  target mode of load.
 wr_addr  in  MAW  row written.
 wr_data  in  RANK_FACTOR_MATRIX x FACTOR_MATRIX_WIDTH  row contents.
 resp_factor_matrices_en  out  NM  per-mode response valid.
 resp_factor_matrices  out  NM x RANK_FACTOR_MATRIX x FACTOR_MATRIX_WIDTH  returned rows.
 resp_compute_id  out  CIDW  id echoed with response.
 err_oob  out  1  sticky: out-of-range row address requested.

Function
REQ-003 Accept = (|req_addr_en) & req_ready; on accept push {en mask, addrs, id} into request FIFO and drive factor_data_ack=1 next cycle (registered), else 0.
REQ-004 req_ready = FIFO not full (combinational from count); requests with req_addr_en=0 are ignored, no ack.
REQ-005 One memory per mode, single read/write port, synchronous read, depth FACTOR_MEM_DEPTH, row width RANK*FACTOR_MATRIX_WIDTH.
REQ-006 Issue stage: pop FIFO head and read all modes whose en bit is set in the same cycle, when FIFO non-empty and wr_en=0.
REQ-007 wr_en=1 has priority: write executes, no pop that cycle; FIFO keeps accepting while not full; wr_mode>=NM ignored.
REQ-008 Response registered one cycle after memory read; latency accept-to-resp = 3 cycles when FIFO empty and wr_en=0; throughput 1 response/cycle.
REQ-009 Response: resp_factor_matrices_en = popped mask; modes with en=0 output all-zero data; resp_compute_id = popped id; en all-zero on non-response cycles, data/id hold last value.
REQ-010 Responses emitted in strict acceptance order; no response backpressure.
REQ-011 Address >= FACTOR_MEM_DEPTH on an enabled mode: returns all-zero row for that mode, response still emitted, err_oob set and held until reset.
REQ-012 Read-after-write: write at cycle T to row R, read of R issued at cycle >T returns new data.
REQ-013 Simultaneous push and pop on a full FIFO: not possible (push blocked by req_ready=0 computed before pop); push and pop on non-full FIFO keep count unchanged.
REQ-014 FIFO pointers wrap modulo REQ_FIFO_DEPTH; count width $clog2(REQ_FIFO_DEPTH)+1.

Reset
REQ-015 rst=0 asynchronously clears: FIFO empty (req_ready=1), factor_data_ack=0, resp_factor_matrices_en=0, resp_factor_matrices=0, resp_compute_id=0, err_oob=0, pipeline valids=0.
REQ-016 Reset mid-operation drops all queued and in-flight requests; no response emitted after release for them.
REQ-017 Memory contents are not reset; undefined until written.

Verification
REQ-018 Load mode0 row 5 = all 0x11111111, mode1 row 9 = all 0x22222222; request en=2'b11, addr={9,5}, id=7 -> ack next cycle, resp en=2'b11, rows match, id=7, exactly 3 cycles after accept.
REQ-019 Hold wr_en=1 for 6 cycles while presenting requests each cycle -> exactly 4 acks, req_ready=0 after 4th, then 4 responses in order once wr_en=0.
REQ-020 Request en=2'b01, mode0 addr=2000 (depth 1024) -> resp en=2'b01, mode0 data 0, err_oob=1 sticky until reset.
REQ-021 Write row 3 then request row 3 next cycle -> new data returned.
REQ-022 Assert rst=0 with 3 requests queued and 1 in flight -> outputs zero immediately, no responses after release, req_ready=1.
REQ-023 Back-to-back 16 requests, wr_en=0 -> 16 acks, 16 consecutive responses in order, ids match.
